manchester_frame_arbiter: RTL and testbench

Round-robin frame arbiter that shares one Manchester transmit chain between N independent framed AXI-Stream sources, such as framer instances. It sits in front of the escape stage and grants the output to one source for exactly one whole frame, bounded by `tlast`. Frames from different sources are never interleaved. An optional inter-frame gap of idle cycles can be inserted so the downstream preamble stage sees clean frame boundaries.

---
 rtl/manchester_pkg.sv | 12 +
 rtl/rr_picker.sv | 28 ++
 rtl/manchester_frame_arbiter.sv | 128 ++++++++++++
 tb/tb_manchester_frame_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/manchester_pkg.sv
// Shared types and constants for the Manchester transmit front end.
package manchester_pkg;

   localparam int unsigned MANCHESTER_BYTE_W = 8;

   typedef enum logic [1:0] {
      StIdle,
      StPass,
      StGap
   } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request searching upward (with wrap)
// from last_grant+1. Returns a one-hot pick and a valid flag.
module rr_picker #(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [N-1:0]     pick,
   output logic             valid
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      pick  = '0;
      valid = 1'b0;
      idx   = '0;
      for (int unsigned off = 1; off <= N; off++) begin
         idx = IDX_W'((32'(last_grant) + off) % N);
         if (!valid && req[idx]) begin
            pick[idx] = 1'b1;
            valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/manchester_frame_arbiter.sv
// Round-robin whole-frame arbiter in front of the Manchester escape stage.
// Optional inter-frame gap compiled in with MANCHESTER_FRAME_ARB_GAP_EN.
module manchester_frame_arbiter
   import manchester_pkg::*;
#(
   parameter int unsigned N_PORTS    = 2,
   parameter int unsigned DATA_WIDTH = MANCHESTER_BYTE_W,
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [N_PORTS-1:0]            s_axis_tvalid,
   output logic [N_PORTS-1:0]            s_axis_tready,
   input  logic [N_PORTS-1:0]            s_axis_tlast,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic [N_PORTS-1:0]            grant,
   output logic                          busy
);

   localparam int unsigned IdxW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   if (N_PORTS < 2 || N_PORTS > 8 || GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_param
      $error("manchester_frame_arbiter: N_PORTS or GAP_CYCLES out of range");
   end

   arb_state_e          state_q;
   logic [N_PORTS-1:0]  grant_q;
   logic [IdxW-1:0]     owner_q;
   logic [IdxW-1:0]     last_grant_q;
   logic                busy_q;
`ifdef MANCHESTER_FRAME_ARB_GAP_EN
   logic [7:0]          gap_cnt_q;
`endif

   logic [N_PORTS-1:0]    pick;
   logic                  pick_valid;
   logic [IdxW-1:0]       pick_idx;
   logic                  pass;
   logic                  own_valid;
   logic                  own_last;
   logic [DATA_WIDTH-1:0] own_data;
   logic                  hs_last;

   rr_picker #(
      .N     (N_PORTS),
      .IDX_W (IdxW)
   ) u_picker (
      .req        (s_axis_tvalid),
      .last_grant (last_grant_q),
      .pick       (pick),
      .valid      (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
         if (pick[i]) pick_idx = IdxW'(i);
      end
   end

   // Zero-latency forwarding of the registered owner; everything is gated by PASS.
   always_comb begin
      pass          = (state_q == StPass);
      own_valid     = s_axis_tvalid[owner_q];
      own_last      = s_axis_tlast[owner_q];
      own_data      = s_axis_tdata[owner_q*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tvalid = pass & own_valid;
      m_axis_tlast  = pass & own_last;
      m_axis_tdata  = pass ? own_data : '0;
      s_axis_tready = pass ? (grant_q & {N_PORTS{m_axis_tready}}) : '0;
      hs_last       = pass & own_valid & own_last & m_axis_tready;
      grant         = grant_q;
      busy          = busy_q;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         owner_q      <= '0;
         last_grant_q <= IdxW'(N_PORTS - 1);
         busy_q       <= 1'b0;
`ifdef MANCHESTER_FRAME_ARB_GAP_EN
         gap_cnt_q    <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pick_valid) begin
                  grant_q <= pick;
                  owner_q <= pick_idx;
                  busy_q  <= 1'b1;
                  state_q <= StPass;
               end
            end
            StPass: begin
               if (hs_last) begin
                  last_grant_q <= owner_q;
                  grant_q      <= '0;
`ifdef MANCHESTER_FRAME_ARB_GAP_EN
                  gap_cnt_q    <= 8'(GAP_CYCLES - 1);
                  state_q      <= StGap;
`else
                  busy_q       <= 1'b0;
                  state_q      <= StIdle;
`endif
               end
            end
`ifdef MANCHESTER_FRAME_ARB_GAP_EN
            StGap: begin
               if (gap_cnt_q == 8'd0) begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 8'd1;
               end
            end
`endif
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_manchester_frame_arbiter.sv
// Scoreboard bench for manchester_frame_arbiter: source beats queued per port,
// expected output beats queued in arbitration order and popped on each handshake.
module tb_manchester_frame_arbiter;

   localparam int N   = 2;
   localparam int DW  = 8;
   localparam int GAP = 4;
`ifdef MANCHESTER_FRAME_ARB_GAP_EN
   localparam int EXP_GAP = GAP + 1;
`else
   localparam int EXP_GAP = 1;
`endif

   logic            aclk = 1'b0;
   logic            aresetn;
   logic [N*DW-1:0] s_axis_tdata;
   logic [N-1:0]    s_axis_tvalid;
   logic [N-1:0]    s_axis_tready;
   logic [N-1:0]    s_axis_tlast;
   logic [DW-1:0]   m_axis_tdata;
   logic            m_axis_tvalid;
   logic            m_axis_tready;
   logic            m_axis_tlast;
   logic [N-1:0]    grant;
   logic            busy;

   always #5 aclk = ~aclk;

   manchester_frame_arbiter #(
      .N_PORTS    (N),
      .DATA_WIDTH (DW),
      .GAP_CYCLES (GAP)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .grant         (grant),
      .busy          (busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Source beats {last, data}; expected output {port, last, data}.
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [9:0] exp_q[$];

   bit bp_en    = 1'b0;
   bit gap_chk  = 1'b0;
   bit prev_last = 1'b0;
   bit hs0, hs1;
   int idle_cnt = 0;
   int hs_cnt   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      logic [8:0] b0, b1;
      b0 = (q0.size() > 0) ? q0[0] : 9'd0;
      b1 = (q1.size() > 0) ? q1[0] : 9'd0;
      s_axis_tvalid = {q1.size() > 0, q0.size() > 0};
      s_axis_tlast  = {b1[8], b0[8]};
      s_axis_tdata  = {b1[7:0], b0[7:0]};
   endtask

   task automatic load(input int port, input logic [7:0] first, input int len);
      logic [8:0] beat;
      for (int k = 0; k < len; k++) begin
         beat = {k == len - 1, first + 8'(k)};
         if (port == 0) q0.push_back(beat);
         else q1.push_back(beat);
         exp_q.push_back({port[0], beat});
      end
      prev_last = 1'b0;
      idle_cnt  = 0;
      drive();
   endtask

   // One clock: monitor at negedge, update sources 1 time unit after posedge.
   task automatic step();
      logic [9:0] e;
      @(negedge aclk);
      hs0 = s_axis_tvalid[0] && s_axis_tready[0];
      hs1 = s_axis_tvalid[1] && s_axis_tready[1];
      check_val("rdy_non_owner", 32'(s_axis_tready & ~grant), 32'd0);
      if (m_axis_tvalid && m_axis_tready) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_beat", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check_val("data", 32'(m_axis_tdata), 32'(e[7:0]));
            check_val("last", 32'(m_axis_tlast), 32'(e[8]));
            check_val("grant", 32'(grant), e[9] ? 32'd2 : 32'd1);
         end
         if (gap_chk && prev_last) check_val("gap", 32'(idle_cnt), 32'(EXP_GAP));
         prev_last = m_axis_tlast;
         idle_cnt  = 0;
         hs_cnt++;
      end else if (!m_axis_tvalid) begin
         idle_cnt++;
      end
      @(posedge aclk);
      #1;
      if (hs0) void'(q0.pop_front());
      if (hs1) void'(q1.pop_front());
      drive();
      m_axis_tready = bp_en ? !m_axis_tready : 1'b1;
   endtask

   task automatic run(input int budget);
      int n = 0;
      while ((exp_q.size() > 0 || q0.size() > 0 || q1.size() > 0) && n < budget) begin
         step();
         n++;
      end
      check_val("drain_exp", 32'(exp_q.size()), 32'd0);
      check_val("drain_src", 32'(q0.size() + q1.size()), 32'd0);
   endtask

   initial begin
      aresetn       = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = '0;
      s_axis_tlast  = '0;
      m_axis_tready = 1'b1;
      #12;
      check_val("rst_grant", 32'(grant), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
      check_val("rst_mdata", 32'(m_axis_tdata), 32'd0);
      check_val("rst_sready", 32'(s_axis_tready), 32'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;

      // Single source, port 0, 0x01..0x08.
      load(0, 8'h01, 8);
      run(200);
      repeat (GAP + 4) step();
      check_val("single_grant_idle", 32'(grant), 32'd0);
      check_val("single_busy_idle", 32'(busy), 32'd0);

      // Reset mid-frame on port 1 (last_grant is 0 here, so only a real reset favours port 0).
      hs_cnt = 0;
      load(1, 8'h30, 8);
      for (int n = 0; n < 100 && hs_cnt < 3; n++) step();
      check_val("rst_mid_beats", 32'(hs_cnt), 32'd3);
      check_val("rst_mid_busy_pre", 32'(busy), 32'd1);
      #2;
      aresetn = 1'b0;
      #1;
      check_val("rst_mid_grant", 32'(grant), 32'd0);
      check_val("rst_mid_busy", 32'(busy), 32'd0);
      check_val("rst_mid_mvalid", 32'(m_axis_tvalid), 32'd0);
      q0.delete();
      q1.delete();
      exp_q.delete();
      load(0, 8'hC0, 4);
      load(1, 8'hD0, 4);
      m_axis_tready = 1'b1;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      run(200);

      // Contention: A frame then B frame, twice; back-to-back gap measured.
      gap_chk = 1'b1;
      for (int r = 0; r < 2; r++) begin
         load(0, 8'hA0, 4);
         load(1, 8'hB0, 4);
         run(200);
      end
      gap_chk = 1'b0;

      // Backpressure with both ports requesting.
      bp_en = 1'b1;
      load(0, 8'h10, 8);
      load(1, 8'h20, 4);
      run(400);
      bp_en = 1'b0;
      repeat (GAP + 4) step();

      // Single-beat frame on port 1.
      load(1, 8'h55, 1);
      run(100);
      check_val("sb_grant_clear", 32'(grant), 32'd0);
      repeat (GAP + 4) step();
      check_val("sb_busy_idle", 32'(busy), 32'd0);
      check_val("sb_mvalid_idle", 32'(m_axis_tvalid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
